// File: rtl/instr_mem_if.sv
// Fetch-side request/response handshake plus the memory load port.
`timescale 1ns/1ps
interface instr_mem_if #(
   parameter int IDX_W = 10
);
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_addr;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_instr;
   logic [31:0]      resp_addr;
   logic             resp_err;
   logic             ld_en;
   logic [IDX_W-1:0] ld_idx;
   logic [31:0]      ld_data;

   modport master (
      output req_valid, req_addr, resp_ready, ld_en, ld_idx, ld_data,
      input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready, ld_en, ld_idx, ld_data,
      output req_ready, resp_valid, resp_instr, resp_addr, resp_err
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory serving fetch requests with a fixed read latency,
// error flagging for bad addresses, and a side load port for programming.
`timescale 1ns/1ps
module instr_mem_responder #(
   parameter int IM_SIZE    = 1024,
   parameter int RD_LATENCY = 2,
   parameter int IDX_W      = $clog2(IM_SIZE)
) (
   input  logic        clk,
   input  logic        rst,
   instr_mem_if.slave  bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam logic [31:0] SIZE_W   = 32'(IM_SIZE);
   localparam logic [3:0]  CNT_INIT = (RD_LATENCY >= 2) ? 4'(RD_LATENCY - 2) : 4'd0;
   localparam bit          LAT1     = (RD_LATENCY == 1);

   state_t      r_state, w_next;
   logic [3:0]  r_cnt;
   logic [31:0] r_cap_addr;
   logic        r_cap_err;
   logic [31:0] r_instr;
   logic [31:0] r_resp_addr;
   logic        r_resp_err;
   logic [31:0] r_mem [IM_SIZE];

   logic             w_req_ready;
   logic             w_accept;
   logic             w_req_err;
   logic             w_load_resp;
   logic [31:0]      w_src_addr;
   logic             w_src_err;
   logic [IDX_W-1:0] w_rd_idx;

   assign w_req_ready = (r_state == ST_IDLE) || (r_state == ST_RESP && bus.resp_ready);
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_req_err   = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> 2) >= SIZE_W);

   // With single-cycle latency the response is loaded straight from the request.
   assign w_load_resp = LAT1 ? w_accept : (r_state == ST_WAIT && r_cnt == 4'd0);
   assign w_src_addr  = LAT1 ? bus.req_addr : r_cap_addr;
   assign w_src_err   = LAT1 ? w_req_err    : r_cap_err;
   assign w_rd_idx    = w_src_addr[IDX_W+1:2];

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = LAT1 ? ST_RESP : ST_WAIT;
         ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
         ST_RESP: if (bus.resp_ready)
                     w_next = w_accept ? (LAT1 ? ST_RESP : ST_WAIT) : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_cap_addr  <= 32'd0;
         r_cap_err   <= 1'b0;
         r_instr     <= 32'd0;
         r_resp_addr <= 32'd0;
         r_resp_err  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cap_addr <= bus.req_addr;
            r_cap_err  <= w_req_err;
            r_cnt      <= CNT_INIT;
         end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_load_resp) begin
            r_resp_addr <= w_src_addr;
            r_resp_err  <= w_src_err;
            r_instr     <= w_src_err ? 32'd0 : r_mem[w_rd_idx];
         end
      end
   end

   // Memory is not reset; a same-edge load lands after the read (old data returned).
   always_ff @(posedge clk) begin
      if (bus.ld_en && (32'(bus.ld_idx) < SIZE_W))
         r_mem[bus.ld_idx] <= bus.ld_data;
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = (r_state == ST_RESP);
   assign bus.resp_instr = r_instr;
   assign bus.resp_addr  = r_resp_addr;
   assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: load, fetch, stream, backpressure,
// error responses, load/read collision and reset during a pending read.
`timescale 1ns/1ps
module tb_instr_mem_responder;
   localparam int IM_SIZE = 1024;
   localparam int IDX_W   = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   instr_mem_if #(.IDX_W(IDX_W)) bus_if ();

   instr_mem_responder #(.IM_SIZE(IM_SIZE), .RD_LATENCY(2), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are then driven, and outputs sampled, 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic [31:0] a);
      bus_if.req_valid = v;
      bus_if.req_addr  = a;
   endtask

   initial begin
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h00000013; exp_w[1] = 32'h00500093;
      exp_w[2] = 32'h00A00113; exp_w[3] = 32'h002081B3;

      req(1'b0, 32'd0);
      bus_if.resp_ready = 1'b1;
      bus_if.ld_en      = 1'b0;
      bus_if.ld_idx     = '0;
      bus_if.ld_data    = 32'd0;

      // reset state
      #12;
      chk("rst_valid", 32'(bus_if.resp_valid), 32'd0);
      chk("rst_instr", bus_if.resp_instr, 32'd0);
      chk("rst_addr",  bus_if.resp_addr, 32'd0);
      chk("rst_err",   32'(bus_if.resp_err), 32'd0);
      chk("rst_ready", 32'(bus_if.req_ready), 32'd1);
      tick();
      rst = 1'b0;

      // program mem[0..3]
      for (int i = 0; i < 4; i++) begin
         bus_if.ld_en   = 1'b1;
         bus_if.ld_idx  = IDX_W'(i);
         bus_if.ld_data = exp_w[i];
         tick();
      end
      bus_if.ld_en = 1'b0;

      // single fetch of 0x4
      req(1'b1, 32'h4);
      #1 chk("t1_ready_idle", 32'(bus_if.req_ready), 32'd1);
      tick();
      req(1'b0, 32'h0);
      chk("t1_wait_valid", 32'(bus_if.resp_valid), 32'd0);
      chk("t1_wait_ready", 32'(bus_if.req_ready), 32'd0);
      tick();
      chk("t1_valid", 32'(bus_if.resp_valid), 32'd1);
      chk("t1_instr", bus_if.resp_instr, 32'h00500093);
      chk("t1_addr",  bus_if.resp_addr, 32'h4);
      chk("t1_err",   32'(bus_if.resp_err), 32'd0);
      tick();
      chk("t1_idle_valid", 32'(bus_if.resp_valid), 32'd0);
      chk("t1_hold_instr", bus_if.resp_instr, 32'h00500093);

      // streaming 0x0..0xC, back-to-back
      req(1'b1, 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("st_wait_valid", 32'(bus_if.resp_valid), 32'd0);
         tick();
         chk("st_valid", 32'(bus_if.resp_valid), 32'd1);
         chk("st_instr", bus_if.resp_instr, exp_w[k]);
         chk("st_addr",  bus_if.resp_addr, 32'(4 * k));
         if (k < 3) req(1'b1, 32'(4 * (k + 1)));
         else       req(1'b0, 32'h0);
      end
      tick();
      chk("st_no_dup", 32'(bus_if.resp_valid), 32'd0);

      // backpressure on 0x8
      bus_if.resp_ready = 1'b0;
      req(1'b1, 32'h8);
      tick();
      req(1'b0, 32'h0);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(bus_if.resp_valid), 32'd1);
         chk("bp_instr", bus_if.resp_instr, 32'h00A00113);
         chk("bp_ready", 32'(bus_if.req_ready), 32'd0);
         tick();
      end
      bus_if.resp_ready = 1'b1;
      req(1'b1, 32'hC);
      #1 chk("bp_release_ready", 32'(bus_if.req_ready), 32'd1);
      tick();
      req(1'b0, 32'h0);
      chk("bp_next_wait", 32'(bus_if.resp_valid), 32'd0);
      tick();
      chk("bp_next_instr", bus_if.resp_instr, 32'h002081B3);
      chk("bp_next_addr",  bus_if.resp_addr, 32'hC);

      // error responses, then a good request
      req(1'b1, 32'h6);
      tick();
      req(1'b0, 32'h0);
      tick();
      chk("err_mis_err",   32'(bus_if.resp_err), 32'd1);
      chk("err_mis_instr", bus_if.resp_instr, 32'd0);
      chk("err_mis_addr",  bus_if.resp_addr, 32'h6);
      req(1'b1, 32'h1000);
      tick();
      req(1'b0, 32'h0);
      tick();
      chk("err_oor_err",   32'(bus_if.resp_err), 32'd1);
      chk("err_oor_instr", bus_if.resp_instr, 32'd0);
      req(1'b1, 32'h8);
      tick();
      req(1'b0, 32'h0);
      tick();
      chk("err_ok_err",   32'(bus_if.resp_err), 32'd0);
      chk("err_ok_instr", bus_if.resp_instr, 32'h00A00113);
      tick();

      // load collision on the read edge of 0x4
      req(1'b1, 32'h4);
      tick();
      req(1'b0, 32'h0);
      bus_if.ld_en   = 1'b1;
      bus_if.ld_idx  = IDX_W'(1);
      bus_if.ld_data = 32'hDEADBEEF;
      tick();
      bus_if.ld_en = 1'b0;
      chk("col_old", bus_if.resp_instr, 32'h00500093);
      req(1'b1, 32'h4);
      tick();
      req(1'b0, 32'h0);
      tick();
      chk("col_new", bus_if.resp_instr, 32'hDEADBEEF);
      tick();

      // reset while in WAIT
      req(1'b1, 32'h8);
      tick();
      req(1'b0, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("rw_valid", 32'(bus_if.resp_valid), 32'd0);
      chk("rw_instr", bus_if.resp_instr, 32'd0);
      tick();
      rst = 1'b0;
      chk("rw_ready", 32'(bus_if.req_ready), 32'd1);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("rw_no_stale", 32'(bus_if.resp_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder that serves the fetch stage over a valid/ready request/response handshake.
- Accepts one word-aligned byte address per request and returns the 32-bit instruction after a fixed, parameterised latency.
- Flags misaligned or out-of-range addresses with an error response.
- Has a write-only load port so the bench or a boot loader can program the memory contents.

Parameters:
- IM_SIZE, 1024, number of 32-bit instruction words in the memory.
- RD_LATENCY, 2, cycles from request acceptance to resp_valid assertion; legal range is 1..15.
- IDX_W, $clog2(IM_SIZE), width of the word index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the requested instruction.
- resp_valid  out  1  response valid.
- resp_ready  in  1  fetch stage accepts the response.
- resp_instr  out  32  returned instruction word.
- resp_addr  out  32  echo of the accepted req_addr.
- resp_err  out  1  1 means misaligned or out-of-range address.
- ld_en  in  1  load-port write enable.
- ld_idx  in  IDX_W  word index to write.
- ld_data  in  32  instruction word to write.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0.
  - Latency counter = 0.
  - Memory contents are NOT cleared.
  - Reset mid-operation discards any pending request; no response is ever issued for it.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). This is combinational and allows back-to-back requests.
- Accept: a request is accepted when req_valid && req_ready. On accept:
  - Capture req_addr.
  - Compute err = (req_addr[1:0]!=0) || ((req_addr>>2) >= IM_SIZE).
  - If RD_LATENCY==1, go to RESP next cycle.
  - Otherwise load counter = RD_LATENCY-2 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, go to RESP on the next edge.
- Entering RESP:
  - Memory is read at the same edge (index = captured_addr[IDX_W+1:2]).
  - resp_instr is registered.
  - If err: resp_instr=0, resp_err=1, and no memory read.
- RESP:
  - resp_valid=1, and all resp_* outputs are held stable until resp_ready=1.
  - On resp_ready with a new accept, restart the latency sequence (RD_LATENCY==1 stays in RESP with the new data).
  - On resp_ready without an accept, go to IDLE with resp_valid=0 on the next cycle.
  - resp_instr, resp_addr and resp_err keep their last values when resp_valid=0.
- Latency: a request accepted at edge N gives resp_valid=1 after edge N+RD_LATENCY.
- Throughput: one response per RD_LATENCY cycles when resp_ready is held high.
- Load port:
  - Writes mem[ld_idx] <= ld_data on the clock edge when ld_en=1, in any state, independent of the handshake.
  - If the write and the response read hit the same index on the same edge, the response returns the OLD data (read-before-write).
  - ld_idx >= IM_SIZE is ignored (no write).
- req_addr and req_valid are ignored when req_ready=0. The requester holds them stable per valid/ready rules.

Test Plan:
- Reset, then load mem[0..3] = 32'h00000013, 32'h00500093, 32'h00A00113, 32'h002081B3. Then req_addr=0x4 with resp_ready=1 -> resp_valid rises 2 cycles after accept with resp_instr=32'h00500093, resp_addr=0x4, resp_err=0.
- Streaming addresses 0x0, 0x4, 0x8, 0xC with resp_ready=1 -> four responses in order with the matching words, one every RD_LATENCY cycles, and no dropped or duplicated responses.
- Backpressure:
  - Request 0x8 with resp_ready=0 for 5 cycles -> resp_valid stays 1, resp_instr=32'h00A00113 is stable, req_ready=0.
  - Then resp_ready=1 -> the response completes and the next request is accepted in that same cycle.
- Error cases:
  - req_addr=0x6 -> resp_err=1, resp_instr=0.
  - req_addr=4*IM_SIZE (0x1000) -> resp_err=1.
  - The next valid request returns normally.
- Load collision: ld_en=1, ld_idx=1, ld_data=32'hDEADBEEF on the read edge for req 0x4 -> that response returns 32'h00500093; a following req 0x4 returns 32'hDEADBEEF.
- Assert rst while in WAIT -> resp_valid=0 immediately; after release, req_ready=1 and no stale response appears.
